rsa_sequencer: RTL and testbench
================================

RSA_SEQUENCER -- requirements
Module: rsa_sequencer

Interface
REQ-001 Parameter: MAX_MULS, default 255, multiply-step limit before abort with error.
REQ-002 Parameter: INIT_TIMEOUT, default 8, WAIT_INIT cycle limit before abort with error.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 req_start  in  1  level request to exponentiate the current data bus value; held until ack_start.
REQ-006 req_e  in  1  level request to load exponent from data bus; held until ack_e.
REQ-007 req_n  in  1  level request to load modulus from data bus; held until ack_n.
REQ-008 ack_start, ack_e, ack_n  out  1 each  one-cycle grant pulses.
REQ-009 is_init_done, is_multiplication_done  in  1 each  registered datapath status flags (one-cycle lag).
REQ-010 initialize, en_multiply, en_modulo, done, update_e, update_n  out  1 each  registered datapath strobes.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 result_valid  out  1  one-cycle pulse; datapath output_data is valid in this cycle.
REQ-013 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-014 States: IDLE, CFG_E, CFG_N, LOAD, WAIT_INIT, MOD, CHECK, MUL, DONE, RESULT, ERR.
REQ-015 At most one datapath strobe is high in any cycle; every strobe is high only in its own state (update_e/CFG_E, update_n/CFG_N, initialize/LOAD, en_modulo/MOD, en_multiply/MUL, done/DONE).
REQ-016 IDLE arbitration, fixed priority req_n > req_e > req_start; one grant per IDLE cycle; requests arriving while busy are held and served on return to IDLE.
REQ-017 CFG_N/CFG_E: one cycle, matching update strobe and ack pulse high together, then IDLE; requester holds data stable through the ack cycle.
REQ-018 LOAD: initialize and ack_start high for one cycle, then WAIT_INIT; multiply counter cleared.
REQ-019 WAIT_INIT: ignore is_init_done in the first WAIT_INIT cycle (stale flag); from the second cycle on, is_init_done=1 goes to MOD.
REQ-020 WAIT_INIT exceeding INIT_TIMEOUT cycles goes to ERR.
REQ-021 Loop: MOD -> CHECK; CHECK with is_multiplication_done=1 goes to DONE, else to MUL; MUL -> MOD, increments the 8-bit multiply counter.
REQ-022 CHECK with is_multiplication_done=0 and multiply counter = MAX_MULS goes to ERR (no further MUL).
REQ-023 DONE: done high one cycle; RESULT: result_valid high one cycle, then IDLE.
REQ-024 ERR: err high one cycle, then IDLE; no result_valid for the aborted operation.
REQ-025 Latency from req_start sampled in IDLE (cycle 0): result_valid in cycle 7 + 3*(e-1).
REQ-026 Requests that drop before their ack are ignored, with no partial strobes.

Reset
REQ-027 rst_n low immediately forces IDLE, clears the multiply and timeout counters, and drives all outputs to 0.
REQ-028 Reset mid-operation discards the operation with no ack, result_valid or err; the datapath is re-sequenced from LOAD on the next granted req_start.

Structure
REQ-029 Shared package rsa_pkg holds the state enum, MAX_MULS and INIT_TIMEOUT defaults, and counter widths.
REQ-030 One sub-module, rsa_req_arbiter: 3-input fixed-priority grant, enabled only in IDLE.
REQ-031 The top holds the FSM, counters and registered strobes; target size is 120-400 RTL lines.

Verification
REQ-032 Default e=17, n=3233, data=65, req_start -> 16 MUL strobes, result_valid at cycle 55, output_data=2790.
REQ-033 req_e with data=1, then req_start with data=100 -> zero MUL strobes, result_valid at cycle 7, output_data=100 mod 3233=100.
REQ-034 req_n, req_e, req_start asserted together in IDLE -> ack_n, then ack_e, then ack_start, in that order on separate grants.
REQ-035 req_e with data=0, then req_start -> 255 MUL strobes, then err pulse, no result_valid, busy low afterwards.
REQ-036 is_init_done held 0 by bench stub -> err after INIT_TIMEOUT=8 WAIT_INIT cycles.
REQ-037 rst_n pulsed low mid-loop (during MUL) -> all outputs 0 asynchronously, IDLE; a new req_start then yields a correct result.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation sequencer: state encoding,
// default limits and counter widths.
package rsa_pkg;

    localparam int MUL_CNT_W            = 8;
    localparam int INIT_CNT_W           = 8;
    localparam int MAX_MULS_DEFAULT     = 255;
    localparam int INIT_TIMEOUT_DEFAULT = 8;

    typedef enum logic [3:0] {
        IDLE,
        CFG_E,
        CFG_N,
        LOAD,
        WAIT_INIT,
        MOD,
        CHECK,
        MUL,
        DONE,
        RESULT,
        ERR
    } rsa_state_e;

endpackage

// File: rtl/rsa_req_arbiter.sv
// Fixed-priority grant (req_n > req_e > req_start), active only while the
// sequencer is idle so at most one request is accepted per idle cycle.
module rsa_req_arbiter (
    input  logic enable,
    input  logic req_n,
    input  logic req_e,
    input  logic req_start,
    output logic grant_n,
    output logic grant_e,
    output logic grant_start
);

    always_comb begin
        grant_n     = enable & req_n;
        grant_e     = enable & ~req_n & req_e;
        grant_start = enable & ~req_n & ~req_e & req_start;
    end

endmodule

// File: rtl/rsa_sequencer.sv
// Control FSM for a multiply/modulo RSA datapath: arbitrates configuration and
// start requests, sequences the multiply loop and aborts on step or init timeouts.
module rsa_sequencer
    import rsa_pkg::*;
#(
    parameter int MAX_MULS     = MAX_MULS_DEFAULT,
    parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_start,
    input  logic       req_e,
    input  logic       req_n,
    input  logic       is_init_done,
    input  logic       is_multiplication_done,
    output logic       ack_start,
    output logic       ack_e,
    output logic       ack_n,
    output logic       initialize,
    output logic       en_multiply,
    output logic       en_modulo,
    output logic       done,
    output logic       update_e,
    output logic       update_n,
    output logic       busy,
    output logic       result_valid,
    output logic       err,
    output rsa_state_e dbg_state
);

    // Handshake: a req_* level sampled high in IDLE is committed; its ack pulses
    // for one cycle together with the matching strobe, and the requester must
    // hold data stable through that cycle and drop the request afterwards.

    rsa_state_e            state, next_state;
    logic [MUL_CNT_W-1:0]  mul_cnt;
    logic [INIT_CNT_W-1:0] init_cnt;
    logic                  grant_n, grant_e, grant_start;

    rsa_req_arbiter u_arbiter (
        .enable      (state == IDLE),
        .req_n       (req_n),
        .req_e       (req_e),
        .req_start   (req_start),
        .grant_n     (grant_n),
        .grant_e     (grant_e),
        .grant_start (grant_start)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_n)          next_state = CFG_N;
                else if (grant_e)     next_state = CFG_E;
                else if (grant_start) next_state = LOAD;
            end
            CFG_E, CFG_N: next_state = IDLE;
            LOAD:         next_state = WAIT_INIT;
            // The first WAIT_INIT cycle still sees the flag from before initialize.
            WAIT_INIT: begin
                if (init_cnt != '0 && is_init_done)
                    next_state = MOD;
                else if (init_cnt == INIT_CNT_W'(INIT_TIMEOUT - 1))
                    next_state = ERR;
            end
            MOD: next_state = CHECK;
            CHECK: begin
                if (is_multiplication_done)                  next_state = DONE;
                else if (mul_cnt == MUL_CNT_W'(MAX_MULS))    next_state = ERR;
                else                                         next_state = MUL;
            end
            MUL:         next_state = MOD;
            DONE:        next_state = RESULT;
            RESULT, ERR: next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mul_cnt  <= '0;
            init_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == LOAD) begin
                mul_cnt  <= '0;
                init_cnt <= '0;
            end
            if (state == WAIT_INIT) init_cnt <= init_cnt + INIT_CNT_W'(1);
            if (state == MUL)       mul_cnt  <= mul_cnt + MUL_CNT_W'(1);
        end
    end

    // Strobes are registered from next_state so each is high exactly in its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_start    <= 1'b0;
            ack_e        <= 1'b0;
            ack_n        <= 1'b0;
            initialize   <= 1'b0;
            en_multiply  <= 1'b0;
            en_modulo    <= 1'b0;
            done         <= 1'b0;
            update_e     <= 1'b0;
            update_n     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            ack_start    <= (next_state == LOAD);
            ack_e        <= (next_state == CFG_E);
            ack_n        <= (next_state == CFG_N);
            initialize   <= (next_state == LOAD);
            en_multiply  <= (next_state == MUL);
            en_modulo    <= (next_state == MOD);
            done         <= (next_state == DONE);
            update_e     <= (next_state == CFG_E);
            update_n     <= (next_state == CFG_N);
            busy         <= (next_state != IDLE);
            result_valid <= (next_state == RESULT);
            err          <= (next_state == ERR);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rsa_sequencer.sv
// Directed bench for rsa_sequencer with a behavioural datapath stub and an
// event scoreboard (acks, results, errors with latency and multiply count).
module tb_rsa_sequencer;
    import rsa_pkg::*;

    localparam logic [3:0] K_ACK_N = 4'd1, K_ACK_E = 4'd2, K_ACK_S = 4'd3,
                           K_RES   = 4'd4, K_ERR   = 4'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_start = 1'b0, req_e = 1'b0, req_n = 1'b0;
    logic is_init_done, is_multiplication_done;
    logic ack_start, ack_e, ack_n, initialize, en_multiply, en_modulo, done;
    logic update_e, update_n, busy, result_valid, err;
    rsa_state_e dbg_state;

    logic [15:0] data = 16'd0;
    logic [31:0] reg_e, reg_n, acc, base, rem;
    logic        stub_block = 1'b0;
    logic [15:0] output_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mul_seen = 0;

    // Expected events: {kind[3:0], cycle[15:0], muls[11:0], data[15:0]}
    logic [47:0] exp_q[$];

    rsa_sequencer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_start              (req_start),
        .req_e                  (req_e),
        .req_n                  (req_n),
        .is_init_done           (is_init_done),
        .is_multiplication_done (is_multiplication_done),
        .ack_start              (ack_start),
        .ack_e                  (ack_e),
        .ack_n                  (ack_n),
        .initialize             (initialize),
        .en_multiply            (en_multiply),
        .en_modulo              (en_modulo),
        .done                   (done),
        .update_e               (update_e),
        .update_n               (update_n),
        .busy                   (busy),
        .result_valid           (result_valid),
        .err                    (err),
        .dbg_state              (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stub: repeated multiply by the base, reduced after every step.
    initial begin
        reg_e = 32'd17;
        reg_n = 32'd3233;
        acc   = 32'd0;
        base  = 32'd0;
        rem   = 32'd0;
    end

    always @(posedge clk) begin
        if (update_e) reg_e <= {16'd0, data};
        if (update_n) reg_n <= {16'd0, data};
        if (initialize) begin
            base <= {16'd0, data} % reg_n;
            acc  <= {16'd0, data} % reg_n;
            rem  <= reg_e - 32'd1;
        end
        if (en_multiply) begin
            acc <= acc * base;
            rem <= rem - 32'd1;
        end
        if (en_modulo) acc <= acc % reg_n;
        is_multiplication_done <= (rem == 32'd0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) is_init_done <= 1'b0;
        else        is_init_done <= (initialize | is_init_done) & ~stub_block;
    end

    assign output_data = acc[15:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic [3:0] kind, input int cycle, input int muls,
                            input logic [15:0] d);
        exp_q.push_back({kind, 16'(cycle), 12'(muls), d});
    endtask

    task automatic score(input logic [47:0] obs);
        logic [47:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                errors++;
                $display("FAIL event: got %0h expected %0h", obs, exp);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones({initialize, en_multiply, en_modulo, done, update_e, update_n}) > 1) begin
                errors++;
                $display("FAIL strobe_onehot: got %b expected at most one",
                         {initialize, en_multiply, en_modulo, done, update_e, update_n});
            end
            if (en_multiply) mul_seen++;
            if (ack_n) score({K_ACK_N, 16'd0, 12'd0, 16'd0});
            if (ack_e) score({K_ACK_E, 16'd0, 12'd0, 16'd0});
            if (ack_start) begin
                start_cyc = cyc;
                mul_seen  = 0;
                score({K_ACK_S, 16'd0, 12'd0, 16'd0});
            end
            if (result_valid) score({K_RES, 16'(cyc - start_cyc + 1), 12'(mul_seen), output_data});
            if (err)          score({K_ERR, 16'(cyc - start_cyc + 1), 12'(mul_seen), 16'd0});
        end
    end

    // Driver: holds each request (and its data) until its ack, in priority order.
    task automatic do_reqs(input logic wn, input logic we, input logic ws,
                           input logic [15:0] dn, input logic [15:0] de, input logic [15:0] ds);
        logic pn, pe, ps, dropped;
        int budget;
        pn = wn; pe = we; ps = ws;
        @(negedge clk);
        data = pn ? dn : (pe ? de : ds);
        req_n = pn; req_e = pe; req_start = ps;
        budget = 0;
        while ((pn || pe || ps) && budget < 4000) begin
            @(negedge clk);
            budget++;
            dropped = 1'b0;
            if (pn && ack_n)     begin pn = 1'b0; req_n = 1'b0;     dropped = 1'b1; end
            if (pe && ack_e)     begin pe = 1'b0; req_e = 1'b0;     dropped = 1'b1; end
            if (ps && ack_start) begin ps = 1'b0; req_start = 1'b0; dropped = 1'b1; end
            if (dropped && (pn || pe || ps)) begin
                @(posedge clk);
                #1 data = pn ? dn : (pe ? de : ds);
            end
        end
        if (pn || pe || ps) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 4000 cycles");
            req_n = 1'b0; req_e = 1'b0; req_start = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        @(negedge clk);
        while (busy && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {52'd0, ack_start, ack_e, ack_n, initialize, en_multiply, en_modulo,
                     done, update_e, update_n, busy, result_valid, err}, 64'd0);
        check({name, "_state"}, {60'd0, dbg_state}, {60'd0, IDLE});
    endtask

    initial begin
        int budget;
        #3 check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("post_reset_idle");

        // Default key: 65^17 mod 3233, plus a request that drops while busy.
        push_evt(K_ACK_S, 0, 0, 16'd0);
        push_evt(K_RES, 55, 16, 16'd2790);
        do_reqs(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd65);
        req_n = 1'b1;
        repeat (5) @(negedge clk);
        req_n = 1'b0;
        wait_idle("idle_after_default");

        // e=1: no multiplies, minimum latency.
        push_evt(K_ACK_E, 0, 0, 16'd0);
        do_reqs(1'b0, 1'b1, 1'b0, 16'd0, 16'd1, 16'd0);
        push_evt(K_ACK_S, 0, 0, 16'd0);
        push_evt(K_RES, 7, 0, 16'd100);
        do_reqs(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd100);
        wait_idle("idle_after_e1");

        // All three together: n, then e=3, then 2^3 mod 3233.
        push_evt(K_ACK_N, 0, 0, 16'd0);
        push_evt(K_ACK_E, 0, 0, 16'd0);
        push_evt(K_ACK_S, 0, 0, 16'd0);
        push_evt(K_RES, 13, 2, 16'd8);
        do_reqs(1'b1, 1'b1, 1'b1, 16'd3233, 16'd3, 16'd2);
        wait_idle("idle_after_priority");

        // e=0 never completes: abort after MAX_MULS multiplies.
        push_evt(K_ACK_E, 0, 0, 16'd0);
        do_reqs(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        push_evt(K_ACK_S, 0, 0, 16'd0);
        push_evt(K_ERR, 771, 255, 16'd0);
        do_reqs(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd7);
        wait_idle("idle_after_mul_limit");
        @(negedge clk);
        check("busy_after_mul_limit", {63'd0, busy}, 64'd0);

        // Restore e=17, then stall init to hit the timeout.
        push_evt(K_ACK_E, 0, 0, 16'd0);
        do_reqs(1'b0, 1'b1, 1'b0, 16'd0, 16'd17, 16'd0);
        stub_block = 1'b1;
        push_evt(K_ACK_S, 0, 0, 16'd0);
        push_evt(K_ERR, 10, 0, 16'd0);
        do_reqs(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd65);
        wait_idle("idle_after_init_timeout");
        stub_block = 1'b0;

        // Reset in the middle of a MUL cycle, then a clean rerun.
        push_evt(K_ACK_S, 0, 0, 16'd0);
        do_reqs(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd65);
        budget = 0;
        while (!en_multiply && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("mul_seen_before_reset", {63'd0, en_multiply}, 64'd1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_evt(K_ACK_S, 0, 0, 16'd0);
        push_evt(K_RES, 55, 16, 16'd2790);
        do_reqs(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd65);
        wait_idle("idle_after_rerun");

        repeat (3) @(negedge clk);
        check("expected_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
